// File: rtl/ttl_check_pkg.sv
// Shared types and defaults for the TTL loop-back input checker.
// Imported by the checker top level and its line synchronizer.
package ttl_check_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARM     = 2'd1,
      MEASURE = 2'd2,
      EVAL    = 2'd3
   } ttl_state_e;

   localparam int DIV_DEF        = 100;
   localparam int WINDOW_US_DEF  = 10;
   localparam int SETTLE_CYC_DEF = 4;
   localparam int MIN_EDGES_DEF  = 2;
   localparam int CNT_W_DEF      = 16;

   typedef logic [CNT_W_DEF-1:0] ttl_count_t;

   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ttl_in_sync.sv
// Two-flop synchronizer for one asynchronous TTL line,
// followed by a registered single-cycle rising-edge pulse.
module ttl_in_sync (
   input  logic clk_100Mz,
   input  logic rst,
   input  logic i_data,
   output logic o_rise
);

   logic r_meta;
   logic r_sync;
   logic r_prev;
   logic r_rise;

   always_ff @(posedge clk_100Mz) begin
      if (rst) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
         r_prev <= 1'b0;
         r_rise <= 1'b0;
      end else begin
         r_meta <= i_data;
         r_sync <= r_meta;
         r_prev <= r_sync;
         r_rise <= r_sync & ~r_prev;
      end
   end

   assign o_rise = r_rise;

endmodule

// File: rtl/ttl_in_check.sv
// Loop-back checker: counts rising edges on both TTL lines over a
// fixed window and grades them against the latched configuration.
module ttl_in_check
   import ttl_check_pkg::*;
#(
   parameter int DIV        = DIV_DEF,
   parameter int WINDOW_US  = WINDOW_US_DEF,
   parameter int SETTLE_CYC = SETTLE_CYC_DEF,
   parameter int MIN_EDGES  = MIN_EDGES_DEF,
   parameter int CNT_W      = CNT_W_DEF
) (
   input  logic             clk_100Mz,
   input  logic             rst,
   input  logic             data_in_0,
   input  logic             data_in_1,
   input  logic             branch_channel,
   input  logic             enable_channel,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic             err_cross,
   output logic [CNT_W-1:0] cnt_0,
   output logic [CNT_W-1:0] cnt_1
);

   localparam int PRE_W = cnt_w(DIV);
   localparam int US_W  = cnt_w(WINDOW_US);
   localparam int SET_W = cnt_w(SETTLE_CYC);

   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);
   localparam logic [US_W-1:0]  US_LAST  = US_W'(WINDOW_US - 1);
   localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYC - 1);

   ttl_state_e       r_state;
   logic [PRE_W-1:0] r_pre;
   logic [US_W-1:0]  r_us;
   logic [SET_W-1:0] r_set;
   logic             r_br;
   logic             r_en;
   logic             r_busy;
   logic             r_done;
   logic             r_pass;
   logic             r_err;
   logic [CNT_W-1:0] r_cnt_0;
   logic [CNT_W-1:0] r_cnt_1;

   logic             w_rise_0;
   logic             w_rise_1;
   logic             w_accept;
   logic [CNT_W-1:0] w_exp;
   logic [CNT_W-1:0] w_oth;
   logic             w_pass;
   logic             w_err;

   ttl_in_sync u_sync_0 (
      .clk_100Mz (clk_100Mz),
      .rst       (rst),
      .i_data    (data_in_0),
      .o_rise    (w_rise_0)
   );

   ttl_in_sync u_sync_1 (
      .clk_100Mz (clk_100Mz),
      .rst       (rst),
      .i_data    (data_in_1),
      .o_rise    (w_rise_1)
   );

   // A start coinciding with the done pulse is dropped.
   assign w_accept = start && (r_state == IDLE) && !r_done;

   assign w_exp = r_br ? r_cnt_1 : r_cnt_0;
   assign w_oth = r_br ? r_cnt_0 : r_cnt_1;

   always_comb begin
      w_pass = 1'b0;
      w_err  = 1'b0;
      if (r_en) begin
         w_pass = (int'(w_exp) >= MIN_EDGES) && (w_oth == '0);
         w_err  = (w_oth != '0);
      end else begin
         w_pass = (r_cnt_0 == '0) && (r_cnt_1 == '0);
         w_err  = (r_cnt_0 != '0) || (r_cnt_1 != '0);
      end
   end

   always_ff @(posedge clk_100Mz) begin
      if (rst) begin
         r_state <= IDLE;
         r_pre   <= '0;
         r_us    <= '0;
         r_set   <= '0;
         r_br    <= 1'b0;
         r_en    <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_pass  <= 1'b0;
         r_err   <= 1'b0;
         r_cnt_0 <= '0;
         r_cnt_1 <= '0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_br    <= branch_channel;
                  r_en    <= enable_channel;
                  r_cnt_0 <= '0;
                  r_cnt_1 <= '0;
                  r_pass  <= 1'b0;
                  r_err   <= 1'b0;
                  r_set   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= ARM;
               end
            end
            ARM: begin
               if (r_set == SET_LAST) begin
                  r_pre   <= '0;
                  r_us    <= '0;
                  r_state <= MEASURE;
               end else begin
                  r_set <= r_set + 1'b1;
               end
            end
            MEASURE: begin
               if (r_pre == PRE_LAST) begin
                  r_pre <= '0;
                  if (r_us == US_LAST) begin
                     r_state <= EVAL;
                  end else begin
                     r_us <= r_us + 1'b1;
                  end
               end else begin
                  r_pre <= r_pre + 1'b1;
               end
               if (w_rise_0 && (r_cnt_0 != '1)) begin
                  r_cnt_0 <= r_cnt_0 + 1'b1;
               end
               if (w_rise_1 && (r_cnt_1 != '1)) begin
                  r_cnt_1 <= r_cnt_1 + 1'b1;
               end
            end
            EVAL: begin
               r_pass  <= w_pass;
               r_err   <= w_err;
               r_done  <= 1'b1;
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign busy      = r_busy;
   assign done      = r_done;
   assign pass      = r_pass;
   assign err_cross = r_err;
   assign cnt_0     = r_cnt_0;
   assign cnt_1     = r_cnt_1;

endmodule

// File: tb/tb_ttl_in_check.sv
// Directed bench for ttl_in_check: a vector table of full checks
// plus config-latch, busy-start, done-start and mid-check reset.
module tb_ttl_in_check;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   logic d0;
   logic d1;
   logic br;
   logic en;
   logic start;

   logic        busy, done, pass, err;
   logic [15:0] cnt0, cnt1;
   logic        s_busy, s_done, s_pass, s_err;
   logic [3:0]  s_cnt0, s_cnt1;

   ttl_in_check u_dut (
      .clk_100Mz      (clk),
      .rst            (rst),
      .data_in_0      (d0),
      .data_in_1      (d1),
      .branch_channel (br),
      .enable_channel (en),
      .start          (start),
      .busy           (busy),
      .done           (done),
      .pass           (pass),
      .err_cross      (err),
      .cnt_0          (cnt0),
      .cnt_1          (cnt1)
   );

   ttl_in_check #(.CNT_W(4)) u_sat (
      .clk_100Mz      (clk),
      .rst            (rst),
      .data_in_0      (d0),
      .data_in_1      (d1),
      .branch_channel (br),
      .enable_channel (en),
      .start          (start),
      .busy           (s_busy),
      .done           (s_done),
      .pass           (s_pass),
      .err_cross      (s_err),
      .cnt_0          (s_cnt0),
      .cnt_1          (s_cnt1)
   );

   typedef struct {
      string nm;
      logic  br;
      logic  en;
      logic  tog0;
      logic  tog1;
      int    p0;
      int    p1;
      int    c0;
      int    c1;
      logic  pass;
      logic  err;
   } vec_t;

   vec_t vecs[10];
   int   n_chk = 0;
   int   n_fail = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic logic drv(input logic tog, input int p,
                                input int k);
      if (tog) return ((k / 5) % 2) != 0;
      return (p >= 0) && (k >= p) && (k < p + 3);
   endfunction

   function automatic int sat(input int c);
      return (c > 15) ? 15 : c;
   endfunction

   task automatic run(input vec_t v, input int flip_at,
                      input int start2_at, input int rst_at,
                      input bit start_on_done);
      int dc;
      dc = -1;
      @(negedge clk);
      br = v.br;
      en = v.en;
      d0 = 1'b0;
      d1 = 1'b0;
      start = 1'b1;
      for (int k = 1; k <= 1200; k++) begin
         @(negedge clk);
         start = (k == start2_at);
         rst = (k == rst_at);
         if (k == flip_at) begin
            br = ~v.br;
            en = ~v.en;
         end
         d0 = drv(v.tog0, v.p0, k);
         d1 = drv(v.tog1, v.p1, k);
         if (k == 1) chk({v.nm, " busy@1"}, int'(busy), 1);
         if (k == rst_at) chk({v.nm, " mid cnt_1"}, int'(cnt1), 70);
         if (k == rst_at + 1) begin
            chk({v.nm, " busy"}, int'(busy), 0);
            chk({v.nm, " pass"}, int'(pass), 0);
            chk({v.nm, " err"}, int'(err), 0);
            chk({v.nm, " cnt_0"}, int'(cnt0), 0);
            chk({v.nm, " cnt_1"}, int'(cnt1), 0);
         end
         if (done) begin
            dc = k;
            if (start_on_done) start = 1'b1;
            break;
         end
      end
      if (rst_at < 0) begin
         chk({v.nm, " done cycle"}, dc, 1006);
         chk({v.nm, " busy@done"}, int'(busy), 0);
         chk({v.nm, " cnt_0"}, int'(cnt0), v.c0);
         chk({v.nm, " cnt_1"}, int'(cnt1), v.c1);
         chk({v.nm, " pass"}, int'(pass), int'(v.pass));
         chk({v.nm, " err"}, int'(err), int'(v.err));
         chk({v.nm, " sat done"}, int'(s_done), 1);
         chk({v.nm, " sat cnt_0"}, int'(s_cnt0), sat(v.c0));
         chk({v.nm, " sat cnt_1"}, int'(s_cnt1), sat(v.c1));
         chk({v.nm, " sat pass"}, int'(s_pass), int'(v.pass));
      end else begin
         chk({v.nm, " no done"}, dc, -1);
      end
      @(negedge clk);
      start = 1'b0;
      rst = 1'b0;
      d0 = 1'b0;
      d1 = 1'b0;
      chk({v.nm, " busy after"}, int'(busy), 0);
      chk({v.nm, " done pulse"}, int'(done), 0);
      if (rst_at < 0) begin
         chk({v.nm, " pass hold"}, int'(pass), int'(v.pass));
         chk({v.nm, " cnt_1 hold"}, int'(cnt1), v.c1);
      end
      repeat (3) @(negedge clk);
   endtask

   initial begin
      vecs[0] = '{"b1_tog1",    1, 1, 0, 1, -1,   -1,  0,   100, 1, 0};
      vecs[1] = '{"b0_both",    0, 1, 1, 1, -1,   -1,  100, 100, 0, 1};
      vecs[2] = '{"dis_quiet",  0, 0, 0, 0, -1,   -1,  0,   0,   1, 0};
      vecs[3] = '{"dis_pulse0", 0, 0, 0, 0, 300,  -1,  1,   0,   0, 1};
      vecs[4] = '{"b1_one",     1, 1, 0, 0, -1,   300, 0,   1,   0, 0};
      vecs[5] = '{"b0_tog0",    0, 1, 1, 0, -1,   -1,  100, 0,   1, 0};
      vecs[6] = '{"last_meas",  0, 0, 0, 0, 1001, -1,  1,   0,   0, 1};
      vecs[7] = '{"first_eval", 0, 0, 0, 0, 1002, -1,  0,   0,   1, 0};
      vecs[8] = '{"arm_edge",   0, 0, 0, 0, 1,    -1,  0,   0,   1, 0};
      vecs[9] = '{"first_meas", 0, 0, 0, 0, 2,    -1,  1,   0,   0, 1};

      rst = 1'b1;
      d0 = 1'b0;
      d1 = 1'b0;
      br = 1'b0;
      en = 1'b0;
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset busy", int'(busy), 0);
      chk("reset done", int'(done), 0);
      chk("reset pass", int'(pass), 0);
      chk("reset err", int'(err), 0);
      chk("reset cnt_0", int'(cnt0), 0);
      chk("reset cnt_1", int'(cnt1), 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 10; i++) begin
         run(vecs[i], -1, -1, -1, 1'b0);
      end

      vecs[0].nm = "cfg_latch";
      run(vecs[0], 200, 500, -1, 1'b1);

      vecs[0].nm = "rst_mid";
      run(vecs[0], -1, -1, 700, 1'b0);

      vecs[2].nm = "recover";
      run(vecs[2], -1, -1, -1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/ttl_in_check.md
# ttl_in_check

Receive-side checker for the TTL output channels of the check unit. After a `start`, it watches two asynchronous TTL input lines for a fixed measurement window and counts rising edges on each line. It then compares the activity against the expected configuration (which branch is selected and whether it is enabled) and reports pass/fail. It sits at the loop-back end of the TTL generator path and serves as the self-test for both output channels.

## Interface
Parameters:
- `DIV`, 100: clk_100Mz cycles per 1 µs tick (internal prescaler).
- `WINDOW_US`, 10: measurement window length in µs ticks, ≥1.
- `SETTLE_CYC`, 4: cycles spent in ARM before counting starts, ≥3.
- `MIN_EDGES`, 2: minimum rising edges required on the expected active line.
- `CNT_W`, 16: edge counter width.

Ports:
- `clk_100Mz`  in  1  sole clock. One clock; reset is synchronous and active-high.
- `rst`  in  1  synchronous reset, active-high.
- `data_in_0`  in  1  TTL line of channel 0, asynchronous.
- `data_in_1`  in  1  TTL line of channel 1, asynchronous.
- `branch_channel`  in  1  expected active channel (1 = channel 1, 0 = channel 0).
- `enable_channel`  in  1  expected enable; 0 means both lines must stay quiet.
- `start`  in  1  single-cycle request to begin a check.
- `busy`  out  1  high from the cycle after an accepted start until done.
- `done`  out  1  one-cycle pulse when the result becomes valid.
- `pass`  out  1  result: expected activity seen, no unexpected activity.
- `err_cross`  out  1  result: edges seen on the channel that should be quiet.
- `cnt_0`  out  CNT_W  rising-edge count of channel 0 for the last window.
- `cnt_1`  out  CNT_W  rising-edge count of channel 1 for the last window.

## Operation
- Each input passes through a 2-FF synchronizer and a rising-edge detector. An edge is counted on the cycle where the synchronized value is 1 and its previous value is 0.
- FSM states:
  - IDLE: waits for `start`; on start, latches `branch_channel`/`enable_channel`, clears both counters and result outputs, then goes to ARM.
  - ARM: waits SETTLE_CYC cycles; edges are not counted; then goes to MEASURE.
  - MEASURE: the prescaler and µs counter start from 0; edges are counted; after WINDOW_US ticks, goes to EVAL.
  - EVAL: computes the result for one cycle, then goes to IDLE.
- Counters saturate at 2^CNT_W−1 and never wrap.
- Result rules, using the latched configuration:
  - If enable = 1, with exp = the count of the selected channel and oth = the count of the other: `pass` = (exp ≥ MIN_EDGES) && (oth == 0); `err_cross` = (oth != 0).
  - If enable = 0: `pass` = (cnt_0 == 0 && cnt_1 == 0); `err_cross` = (cnt_0 != 0 || cnt_1 != 0).
- `start` is ignored while busy. Configuration input changes during a check have no effect.
- `pass`, `err_cross`, `cnt_0` and `cnt_1` hold their values until the next accepted `start` or reset.

## Timing
- Reset values: state = IDLE; `busy`, `done`, `pass`, `err_cross` = 0; `cnt_0`, `cnt_1` = 0; synchronizer flops = 0.
- Reset asserted mid-check aborts the check immediately: there is no `done` pulse and all outputs go to their reset values on the next edge.
- Input latency: a pin edge is counted 3 cycles after it is sampled (2 synchronizer flops plus the edge-detect register).
- Cycle timeline after `start` is sampled high at cycle 0:
  - `busy` = 1 from cycle 1.
  - MEASURE spans exactly WINDOW_US·DIV cycles, beginning at cycle 1+SETTLE_CYC.
  - `done` = 1 and the results become valid in the same cycle, at cycle 1+SETTLE_CYC+WINDOW_US·DIV+1.
  - `busy` drops in that same cycle.
- `start` arriving in the same cycle as `done` is ignored. `start` is accepted from the following cycle onward.
- An edge detected in the last MEASURE cycle is counted. An edge detected in the first EVAL cycle is not.

## Structure
- Package `ttl_check_pkg`:
  - state enum (IDLE, ARM, MEASURE, EVAL);
  - default parameter constants;
  - a `ttl_count_t` typedef sized by CNT_W.
- Sub-module `ttl_in_sync`: 2-FF synchronizer plus rising-edge pulse, instantiated once per input line.
- The top level holds the FSM, prescaler, window counter, both counters and the result logic.

## Test plan
All scenarios use defaults, so the window is 1000 cycles.
- branch = 1, enable = 1, data_in_1 toggling with a 10-cycle period, data_in_0 held at 0 → `done` after 1006 cycles, cnt_1 = 100, cnt_0 = 0, `pass` = 1, `err_cross` = 0.
- branch = 0, enable = 1, both lines toggling → cnt_0 = cnt_1 = 100, `pass` = 0, `err_cross` = 1.
- enable = 0, both lines quiet → `pass` = 1. Repeat with a single pulse on data_in_0 → cnt_0 = 1, `pass` = 0, `err_cross` = 1.
- branch = 1, enable = 1, one pulse on data_in_1 → cnt_1 = 1 (< MIN_EDGES), `pass` = 0, `err_cross` = 0.
- Second `start` at cycle 500 while busy, plus config flipped at cycle 200 → the second start is ignored and the result uses the latched config. Then assert `rst` at cycle 700 of a fresh check → no `done`, all outputs 0.
- CNT_W = 4 with 100 edges on the active line → cnt = 15 (saturated), `pass` = 1.
